// File: rtl/mem_ctrl.sv
// Byte-wide single-port RAM controller: IF bytes pass straight through, MEM
// loads/stores of 1/2/4 bytes run as multi-cycle transactions that preempt IF.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | RAM port follows if_addr; waiting for a MEM request
// RD    | issuing load byte addresses, collecting bytes one cycle late
// FIN   | last load byte arrives; result extended and registered
// WR    | writing one store byte per cycle

module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_request,
    input  logic [31:0]       if_addr,
    output logic [7:0]        mem_ctrl_data,
    input  logic [1:0]        mem_request,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_width,
    input  logic              mem_sign,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_FIN, S_WR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  last_cnt;
    logic [31:0] base_addr;
    logic        sign_r;
    logic [31:0] wdata_r;
    logic [31:0] rd_buf;
    logic        req_valid;
    logic        accept;
    logic [31:0] cur_addr;
    logic [31:0] assembled;
    logic [31:0] extended;
    logic        if_unused;

    assign req_valid     = (mem_request == 2'd1) || (mem_request == 2'd2);
    // A request seen alongside mem_done is the tail of the one just finished.
    assign accept        = (state == S_IDLE) && req_valid && !mem_done;
    assign cur_addr      = base_addr + {30'd0, cnt};
    assign mem_busy      = (state != S_IDLE) || (req_valid && !mem_done);
    assign mem_ctrl_data = ram_din;
    assign if_unused     = if_request;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (mem_request == 2'd1) ? S_RD : S_WR;
                end
            end
            S_RD: begin
                if (cnt == last_cnt) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: state_nxt = S_IDLE;
            S_WR: begin
                if (cnt == last_cnt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_a    = if_addr[ADDR_W-1:0];
        ram_wr   = 1'b0;
        ram_dout = 8'd0;
        case (state)
            S_RD, S_FIN: begin
                ram_a = cur_addr[ADDR_W-1:0];
            end
            S_WR: begin
                ram_a    = cur_addr[ADDR_W-1:0];
                ram_wr   = 1'b1;
                ram_dout = wdata_r[{cnt, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Final byte is merged straight from ram_din so FIN can register the result.
    always_comb begin
        assembled = rd_buf;
        assembled[{last_cnt, 3'b000} +: 8] = ram_din;
        extended = assembled;
        case (last_cnt)
            2'd0:    extended = {{24{sign_r & assembled[7]}}, assembled[7:0]};
            2'd1:    extended = {{16{sign_r & assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            last_cnt  <= 2'd0;
            base_addr <= 32'd0;
            sign_r    <= 1'b0;
            wdata_r   <= 32'd0;
            rd_buf    <= 32'd0;
            mem_rdata <= 32'd0;
            mem_done  <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        base_addr <= mem_addr;
                        last_cnt  <= (mem_width == 2'd0) ? 2'd0 :
                                     (mem_width == 2'd1) ? 2'd1 : 2'd3;
                        sign_r    <= mem_sign;
                        wdata_r   <= mem_wdata;
                        cnt       <= 2'd0;
                    end
                end
                S_RD: begin
                    if (cnt != 2'd0) begin
                        rd_buf[{cnt - 2'd1, 3'b000} +: 8] <= ram_din;
                    end
                    if (cnt != last_cnt) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_FIN: begin
                    mem_rdata <= extended;
                    mem_done  <= 1'b1;
                end
                S_WR: begin
                    if (cnt == last_cnt) begin
                        mem_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
